register_file_wb: RTL and testbench

//  Integer register file that terminates the writeback path: consumes RegWriteW/RdW/ResultW from the

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pending_counter.sv | 44 ++++
 rtl/register_file_wb.sv | 131 +++++++++++++
 tb/tb_register_file_wb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-datapath definitions for the writeback/decode register file.
// Contents:
//   XLEN, REG_ADDR_W, NREG  - datapath width, register address width, register count
//   X0                      - address of the hardwired zero register
//   is_write_to             - helper: a valid write/issue targets a given register
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  // True when a qualified access (valid) names register idx.
  function automatic logic is_write_to(input logic                  valid,
                                       input logic [REG_ADDR_W-1:0] addr,
                                       input logic [REG_ADDR_W-1:0] idx);
    return valid && (addr == idx);
  endfunction

endpackage

// File: rtl/pending_counter.sv
// Outstanding-write counter for one architectural register.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-low reset
//   inc        - an instruction writing this register issues this cycle
//   dec        - a write to this register retires this cycle
//   cnt        - number of writes currently in flight
//   sat_hit    - an increment was refused because the counter is full
module pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count issues up and retirements down; saturate at both ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (inc && !dec) begin
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else if (dec && !inc) begin
      // A retirement nobody counted (e.g. issued before reset) is legal.
      if (cnt_r != CNT_ZERO) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  assign cnt     = cnt_r;
  assign sat_hit = inc && !dec && (cnt_r == CNT_MAX);

endmodule

// File: rtl/register_file_wb.sv
// Integer register file terminating the writeback path.
// Ports:
//   clk, rst                   - rising-edge clock, asynchronous active-low reset
//   RegWriteW, RdW, ResultW    - register write retiring from writeback
//   IssueD, RegWriteD, RdD     - instruction leaving decode and its destination
//   A1, A2 / RD1, RD2          - combinational read ports with write-first bypass
//   HazardD                    - a read source still has a write in flight
//   OvfErr                     - sticky: issue attempted on a saturated counter
module register_file_wb
  import riscv_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  IssueD,
  input  logic                  RegWriteD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  output logic [XLEN-1:0]       RD1,
  output logic [XLEN-1:0]       RD2,
  output logic                  HazardD,
  output logic                  OvfErr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]  regs_r [NREG];
  logic [CNT_W-1:0] cnt_s  [NREG];
  logic [NREG-1:1]  inc_s;
  logic [NREG-1:1]  dec_s;
  logic [NREG-1:1]  sat_hit_s;
  logic             ovf_err_r;
  logic [XLEN-1:0]  rd1_s;
  logic [XLEN-1:0]  rd2_s;
  logic             hazard_s;

  // Register storage; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (RegWriteW && (RdW != X0)) begin
      regs_r[RdW] <= ResultW;
    end
  end

  assign cnt_s[0] = {CNT_W{1'b0}};

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
      assign inc_s[r] = is_write_to(IssueD && RegWriteD, RdD, REG_ADDR_W'(r));
      assign dec_s[r] = is_write_to(RegWriteW, RdW, REG_ADDR_W'(r));

      pending_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc_s[r]),
        .dec     (dec_s[r]),
        .cnt     (cnt_s[r]),
        .sat_hit (sat_hit_s[r])
      );
    end
  endgenerate

  // Write-first read: a value retiring this cycle wins over the stored copy.
  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr,
                                                input logic [XLEN-1:0]       stored);
    logic [XLEN-1:0] val;
    if (addr == X0) begin
      val = {XLEN{1'b0}};
    end else if (is_write_to(RegWriteW, RdW, addr)) begin
      val = ResultW;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // A single outstanding write that retires now is served by the bypass.
  function automatic logic port_hazard(input logic [REG_ADDR_W-1:0] addr,
                                       input logic [CNT_W-1:0]      cnt);
    logic haz;
    if (addr == X0) begin
      haz = 1'b0;
    end else if (cnt > CNT_ONE) begin
      haz = 1'b1;
    end else if (cnt == CNT_ONE) begin
      haz = !is_write_to(RegWriteW, RdW, addr);
    end else begin
      haz = 1'b0;
    end
    return haz;
  endfunction

  // Read muxes and hazard reduction; forced quiet while reset is asserted.
  always_comb begin
    rd1_s    = {XLEN{1'b0}};
    rd2_s    = {XLEN{1'b0}};
    hazard_s = 1'b0;
    if (rst) begin
      rd1_s    = read_port(A1, regs_r[A1]);
      rd2_s    = read_port(A2, regs_r[A2]);
      hazard_s = port_hazard(A1, cnt_s[A1]) || port_hazard(A2, cnt_s[A2]);
    end else begin
      rd1_s    = {XLEN{1'b0}};
      rd2_s    = {XLEN{1'b0}};
      hazard_s = 1'b0;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err_r <= 1'b0;
    end else if (|sat_hit_s) begin
      ovf_err_r <= 1'b1;
    end
  end

  assign RD1     = rd1_s;
  assign RD2     = rd2_s;
  assign HazardD = hazard_s;
  assign OvfErr  = ovf_err_r;

endmodule

// File: tb/tb_register_file_wb.sv
module tb_register_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        IssueD;
  logic        RegWriteD;
  logic [4:0]  RdD;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        HazardD;
  logic        OvfErr;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural values, in-flight write counts, sticky overflow.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ovf;

  register_file_wb dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .IssueD(IssueD), .RegWriteD(RegWriteD), .RdD(RdD),
    .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .HazardD(HazardD), .OvfErr(OvfErr)
  );

  always #5 clk = ~clk;

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_cnt[i]  = 0;
    end
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return m_regs[a];
  endfunction

  function automatic bit m_haz_port(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_cnt[a] >= 2) return 1'b1;
    return (m_cnt[a] == 1) && !(RegWriteW && RdW == a);
  endfunction

  task automatic check_model(input string tag);
    ck({tag, "_rd1"}, RD1, m_read(A1));
    ck({tag, "_rd2"}, RD2, m_read(A2));
    ck({tag, "_haz"}, {31'd0, HazardD}, {31'd0, rst && (m_haz_port(A1) || m_haz_port(A2))});
    ck({tag, "_ovf"}, {31'd0, OvfErr}, {31'd0, m_ovf});
  endtask

  task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                       input logic iss, input logic rwd, input logic [4:0] rdd,
                       input logic [4:0] a1, input logic [4:0] a2);
    RegWriteW = rw; RdW = rdw; ResultW = res;
    IssueD = iss; RegWriteD = rwd; RdD = rdd;
    A1 = a1; A2 = a2;
  endtask

  // Advance one clock edge and apply the architectural effect of that edge to the model.
  task automatic tick();
    bit inc, dec;
    @(posedge clk);
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        inc = IssueD && RegWriteD && (RdD == r[4:0]);
        dec = RegWriteW && (RdW == r[4:0]);
        if (inc && !dec) begin
          if (m_cnt[r] == 3) m_ovf = 1'b1;
          else m_cnt[r]++;
        end else if (dec && !inc && m_cnt[r] > 0) begin
          m_cnt[r]--;
        end
      end
      if (RegWriteW && RdW != 5'd0) m_regs[RdW] = ResultW;
    end
    #1;
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #3;
    check_model("por");
    ck("por_ovf", {31'd0, OvfErr}, 32'd0);
    #4 rst = 1'b1;
    tick();

    // Write-first bypass, then the stored copy on the next cycle.
    drive(1'b1, 5'd7, 32'h12345678, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7);
    #3;
    ck("byp_rd1", RD1, 32'h12345678);
    ck("byp_rd2", RD2, 32'h12345678);
    check_model("byp");
    tick();
    drive(1'b0, 5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7);
    #3;
    ck("byp_held_rd1", RD1, 32'h12345678);
    ck("byp_held_rd2", RD2, 32'h12345678);
    tick();

    // x0: writes dropped, issues untracked.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #3;
    ck("x0_rd1_pre", RD1, 32'd0);
    ck("x0_haz_pre", {31'd0, HazardD}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #3;
    ck("x0_rd1_post", RD1, 32'd0);
    ck("x0_haz_post", {31'd0, HazardD}, 32'd0);

    // Single in-flight write to x3.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    #3;
    check_model("iss3");
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    #3;
    ck("haz3_pending", {31'd0, HazardD}, 32'd1);
    tick();
    drive(1'b1, 5'd3, 32'hA5A50003, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
    #3;
    ck("haz3_retire", {31'd0, HazardD}, 32'd0);
    ck("haz3_bypass", RD1, 32'hA5A50003);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3);
    #3;
    ck("haz3_clear", {31'd0, HazardD}, 32'd0);

    // Simultaneous issue and retirement on x9.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h00009999, 1'b1, 1'b1, 5'd9, 5'd0, 5'd9);
    #3;
    ck("sim9_same", {31'd0, HazardD}, 32'd0);
    check_model("sim9");
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
    #3;
    ck("sim9_next", {31'd0, HazardD}, 32'd1);
    drive(1'b1, 5'd9, 32'h00009998, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
    tick();

    // Saturation on x4: the fourth issue overflows.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0);
      #3;
      check_model("sat_iss");
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0);
      #3;
      ck("sat_ovf", {31'd0, OvfErr}, (i == 3) ? 32'd1 : 32'd0);
      ck("sat_haz", {31'd0, HazardD}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd4, $urandom, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4);
      #3;
      check_model("sat_wb");
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0);
    #3;
    ck("sat_drained_haz", {31'd0, HazardD}, 32'd0);
    ck("sat_sticky_ovf", {31'd0, OvfErr}, 32'd1);

    // Mid-run reset with x5 populated and two writes in flight.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    tick();
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5);
    #3;
    ck("prerst_rd1", RD1, 32'hDEADBEEF);
    ck("prerst_haz", {31'd0, HazardD}, 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    ck("rst_rd1", RD1, 32'd0);
    ck("rst_haz", {31'd0, HazardD}, 32'd0);
    ck("rst_ovf", {31'd0, OvfErr}, 32'd0);
    drive(1'b1, 5'd5, 32'h00001234, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    ck("rst_byp_rd1", RD1, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5);
    #3;
    ck("postrst_rd1", RD1, 32'd0);
    ck("postrst_haz", {31'd0, HazardD}, 32'd0);
    tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom,
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
            5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
      #3;
      check_model("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
